// File: rtl/nbit_serial_comparator.sv
// Bit-serial magnitude comparator: walks two captured WIDTH-bit operands MSB first and
// stops at the first differing bit, reporting GT/EQ/LT with a start/done handshake.
module nbit_serial_comparator #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InStart,
  input  logic             InSigned,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic             OutBusy,
  output logic             OutDone,
  output logic             OutGT,
  output logic             OutEQ,
  output logic             OutLT
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;
  logic [IW-1:0]    idx;

  logic       bit_a;
  logic       bit_b;
  logic       decided;
  logic [2:0] verdict;   // {gt, eq, lt}

  assign bit_a = op_a[idx];
  assign bit_b = op_b[idx];

  // In two's-complement mode the MSB is the sign, so a set bit there means the smaller value.
  always_comb begin
    decided = 1'b0;
    verdict = 3'b000;
    if (bit_a != bit_b) begin
      decided = 1'b1;
      if ((idx == MSB_IDX) && op_signed)
        verdict = bit_a ? 3'b001 : 3'b100;
      else
        verdict = bit_a ? 3'b100 : 3'b001;
    end else if (idx == '0) begin
      decided = 1'b1;
      verdict = 3'b010;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      idx       <= '0;
      OutBusy   <= 1'b0;
      OutDone   <= 1'b0;
      OutGT     <= 1'b0;
      OutEQ     <= 1'b0;
      OutLT     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          OutDone <= 1'b0;
          if (InStart) begin
            op_a      <= InA;
            op_b      <= InB;
            op_signed <= InSigned & SIGNED_EN;
            idx       <= MSB_IDX;
            OutBusy   <= 1'b1;
            state     <= CMP;
          end else begin
            OutBusy <= 1'b0;
            state   <= IDLE;
          end
        end
        CMP: begin
          if (decided) begin
            {OutGT, OutEQ, OutLT} <= verdict;
            OutDone <= 1'b1;
            OutBusy <= 1'b0;
            state   <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          OutBusy <= 1'b0;
          OutDone <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_serial_comparator.sv
// Checks the serial comparator at WIDTH=8 (directed + random with a behavioural model)
// and at WIDTH=2 against the exhaustive operand table.
module tb_nbit_serial_comparator;

  logic       clk;
  logic       rst_n;

  logic       start8, sgn8;
  logic [7:0] a8, b8;
  logic       busy8, done8, gt8, eq8, lt8;

  logic       start2, sgn2;
  logic [1:0] a2, b2;
  logic       busy2, done2, gt2, eq2, lt2;

  int checks = 0;
  int errors = 0;
  logic [2:0] last_flags8 = 3'b000;

  nbit_serial_comparator #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .InStart(start8), .InSigned(sgn8), .InA(a8), .InB(b8),
    .OutBusy(busy8), .OutDone(done8), .OutGT(gt8), .OutEQ(eq8), .OutLT(lt8)
  );

  nbit_serial_comparator #(.WIDTH(2), .SIGNED_EN(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .InStart(start2), .InSigned(sgn2), .InA(a2), .InB(b2),
    .OutBusy(busy2), .OutDone(done2), .OutGT(gt2), .OutEQ(eq2), .OutLT(lt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Golden compare on plain integers, sign-extending by hand in signed mode.
  function automatic logic [2:0] model_flags(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic s);
    longint av, bv;
    av = longint'(a);
    bv = longint'(b);
    if (s) begin
      if (a[w-1]) av = av - (longint'(1) << w);
      if (b[w-1]) bv = bv - (longint'(1) << w);
    end
    if (av > bv) return 3'b100;
    if (av == bv) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from start edge to OutDone: WIDTH - (index of first differing bit), else WIDTH.
  function automatic int model_lat(input int w, input logic [31:0] a, input logic [31:0] b);
    for (int i = w - 1; i >= 0; i--)
      if (a[i] != b[i]) return w - i;
    return w;
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit noise, input string tag);
    int lat;
    int n;
    logic [2:0] ef;
    lat = model_lat(8, {24'd0, a}, {24'd0, b});
    ef  = model_flags(8, {24'd0, a}, {24'd0, b}, s);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
    @(posedge clk); #1;
    n = 0;
    chk({tag, "/busy_after_start"}, {31'd0, busy8}, 32'd1);
    while (n < 12) begin
      @(negedge clk);
      if (noise && (n + 1 <= lat)) begin
        start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done8 === 1'b1) break;
      chk({tag, "/busy_in_cmp"}, {31'd0, busy8}, 32'd1);
    end
    chk({tag, "/done"}, {31'd0, done8}, 32'd1);
    chk({tag, "/latency"}, n, lat);
    chk({tag, "/flags"}, {29'd0, gt8, eq8, lt8}, {29'd0, ef});
    chk({tag, "/busy_at_done"}, {31'd0, busy8}, 32'd0);
    last_flags8 = ef;
    $display("op8 %s a=%02h b=%02h signed=%0d lat=%0d flags=%03b", tag, a, b, s, n,
             {gt8, eq8, lt8});
  endtask

  task automatic idle8(input string tag);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/done_pulse_one_cycle"}, {31'd0, done8}, 32'd0);
    chk({tag, "/busy_idle"}, {31'd0, busy8}, 32'd0);
    chk({tag, "/flags_held"}, {29'd0, gt8, eq8, lt8}, {29'd0, last_flags8});
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic s);
    int n;
    logic [2:0] ef;
    ef = model_flags(2, {30'd0, a}, {30'd0, b}, s);
    @(negedge clk);
    start2 = 1'b1; a2 = a; b2 = b; sgn2 = s;
    @(posedge clk); #1;
    n = 0;
    while (n < 6) begin
      @(negedge clk);
      start2 = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done2 === 1'b1) break;
    end
    chk("w2/done", {31'd0, done2}, 32'd1);
    chk("w2/latency", n, model_lat(2, {30'd0, a}, {30'd0, b}));
    chk("w2/flags", {29'd0, gt2, eq2, lt2}, {29'd0, ef});
    $display("op2 a=%0d b=%0d signed=%0d lat=%0d flags=%03b", a, b, s, n, {gt2, eq2, lt2});
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sgn2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", {31'd0, busy8}, 32'd0);
    chk("reset/done", {31'd0, done8}, 32'd0);
    chk("reset/flags", {29'd0, gt8, eq8, lt8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sign handling at the MSB, then an op that leaves flags set before the abort test.
    do_op8(8'h80, 8'h7F, 1'b0, 1'b0, "msb_unsigned");
    idle8("msb_unsigned");
    do_op8(8'h80, 8'h7F, 1'b1, 1'b0, "msb_signed");
    idle8("msb_signed");

    // Abort mid-compare: 0x0F vs 0x0E needs 8 cycles, reset lands at cycle 3.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0E; sgn8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort/busy", {31'd0, busy8}, 32'd0);
    chk("abort/done", {31'd0, done8}, 32'd0);
    chk("abort/flags", {29'd0, gt8, eq8, lt8}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      chk("abort/no_done", {31'd0, done8}, 32'd0);
    end
    last_flags8 = 3'b000;
    chk("abort/flags_after", {29'd0, gt8, eq8, lt8}, 32'd0);
    do_op8(8'h0F, 8'h0E, 1'b0, 1'b0, "after_abort");
    idle8("after_abort");

    do_op8(8'h5A, 8'h5A, 1'b0, 1'b0, "equal");
    idle8("equal");
    do_op8(8'h10, 8'h11, 1'b0, 1'b0, "lsb_lt");
    idle8("lsb_lt");
    do_op8(8'h34, 8'h30, 1'b1, 1'b0, "bit2_gt");
    idle8("bit2_gt");

    // Start pulses and operand churn during CMP, then a start on the DONE cycle.
    do_op8(8'h01, 8'h00, 1'b1, 1'b1, "noisy");
    do_op8(8'hFF, 8'h00, 1'b1, 1'b0, "back_to_back");
    idle8("back_to_back");

    for (int k = 0; k < 10000; k++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? (ra ^ (8'h01 << $urandom_range(0, 7))) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op8(ra, rb, 1'($urandom), 1'($urandom), "rand");
      if ($urandom_range(0, 1) == 1) idle8("rand");
    end

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          do_op2(2'(a), 2'(b), 1'(s));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
